// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the constants describing the byte-stream frame layout.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 8 * HDR_LEN;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word shift register: each new byte enters at the top,
// so after four shifts the first byte sits in bits 7:0.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [7:0]            in_byte,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  last
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [DATA_WIDTH-1:0] word_q;
  logic [CW-1:0]         count;

  // word_next is the word as it will look once in_byte is shifted in
  assign word_next = {in_byte, word_q[DATA_WIDTH-1:8]};
  assign last      = (count == CW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      count  <= '0;
    end else if (clear) begin
      word_q <= '0;
      count  <= '0;
    end else if (shift) begin
      word_q <= word_next;
      count  <= count + CW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction
// memory and holds the processor in reset until a load completes cleanly.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_rst
);

  localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH + 1)'(2 ** ADDR_WIDTH);
  localparam logic [LEN_WIDTH:0] CNT_ONE   = (LEN_WIDTH + 1)'(1);

  state_t state, next_state;

  logic [7:0]            len_lo;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH:0]    word_cnt;
  logic [7:0]            checksum;
  logic [LEN_WIDTH:0]    len_req;
  logic [DATA_WIDTH-1:0] pack_word;
  logic                  pack_last;
  logic                  accept;
  logic                  start_take;

  assign accept     = in_valid && in_ready;
  assign start_take = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign len_req    = {1'b0, in_data, len_lo};

  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_take),
    .shift     (accept && state == ST_DATA),
    .in_byte   (in_data),
    .word_next (pack_word),
    .last      (pack_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    mem_we     = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_rst    = 1'b1;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        busy    = 1'b0;
        done    = (state == ST_DONE);
        error   = (state == ST_ERROR);
        cpu_rst = (state != ST_DONE);
        if (start) next_state = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        in_ready = 1'b1;
        if (accept) next_state = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        in_ready = 1'b1;
        // Zero-length or over-capacity frames are rejected before any write
        if (accept) begin
          if (len_req == '0 || len_req > MAX_WORDS) next_state = ST_ERROR;
          else                                      next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        if (accept && pack_last) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        if (word_cnt + CNT_ONE < {1'b0, len}) next_state = ST_DATA;
        else                                 next_state = ST_CHECK;
      end
      ST_CHECK: begin
        in_ready = 1'b1;
        if (accept) next_state = (in_data == checksum) ? ST_DONE : ST_ERROR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Frame bookkeeping; the write port is loaded as the fourth byte arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo    <= '0;
      len       <= '0;
      word_cnt  <= '0;
      checksum  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            len_lo   <= '0;
            len      <= '0;
            word_cnt <= '0;
            checksum <= '0;
          end
        end
        ST_LEN_LO: if (accept) len_lo <= in_data;
        ST_LEN_HI: if (accept) len <= {in_data, len_lo};
        ST_DATA: begin
          if (accept) begin
            checksum <= checksum ^ in_data;
            if (pack_last) begin
              mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              mem_wdata <= pack_word;
            end
          end
        end
        ST_WRITE: word_cnt <= word_cnt + CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are streamed byte by byte and every
// memory write is logged on the falling edge for later comparison.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_rst;

  int checks = 0;
  int errors = 0;

  logic [31:0] payload [256];
  logic [7:0]  log_addr [300];
  logic [31:0] log_data [300];
  int          wr_count = 0;
  int          ready_viol = 0;

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_rst   (cpu_rst)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_count < 300) begin
        log_addr[wr_count] = mem_addr;
        log_data[wr_count] = mem_wdata;
      end
      wr_count++;
      if (in_ready) ready_viol++;
    end
  end

  function automatic logic [7:0] csum_of(input int nwords);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < nwords; i++)
      c = c ^ payload[i][7:0] ^ payload[i][15:8] ^ payload[i][23:16] ^ payload[i][31:24];
    return c;
  endfunction

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL in_ready_timeout: got in_ready=0 want 1 for byte %h", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] n, input int nwords, input logic [7:0] csum, input int gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int w = 0; w < nwords; w++)
      for (int k = 0; k < 4; k++) send_byte(payload[w][8*k +: 8], gap);
    send_byte(csum, gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 00", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({done, error} !== 2'b00) begin errors++; $display("[TB] FAIL reset_done_error: got %b want 00", {done, error}); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
  endtask

  task automatic test_single_word();
    wr_count = 0;
    pulse_start();
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got busy=%b ready=%b want 1 1", busy, in_ready); end
    payload[0] = 32'h00A00513;
    send_frame(16'h0001, 1, 8'hB6, 0);
    checks++; if (wr_count !== 1) begin errors++; $display("[TB] FAIL single_wr_count: got %0d want 1", wr_count); end
    checks++; if (log_addr[0] !== 8'h00 || log_data[0] !== 32'h00A00513) begin errors++; $display("[TB] FAIL single_write: got %h/%h want 00/00a00513", log_addr[0], log_data[0]); end
    checks++; if ({done, error, cpu_rst, busy} !== 4'b1000) begin errors++; $display("[TB] FAIL single_status: got d/e/c/b=%b want 1000", {done, error, cpu_rst, busy}); end
    checks++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h00A00513) begin errors++; $display("[TB] FAIL single_hold: got %h/%h want 00/00a00513", mem_addr, mem_wdata); end
  endtask

  task automatic test_toggle_valid();
    wr_count = 0;
    ready_viol = 0;
    pulse_start();
    checks++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL restart_from_done: got cpu_rst=%b done=%b want 1 0", cpu_rst, done); end
    payload[0] = 32'h11223344;
    payload[1] = 32'hDEADBEEF;
    payload[2] = 32'h00000001;
    send_byte(8'h03, 1);
    send_byte(8'h00, 1);
    // start while busy must be ignored
    pulse_start();
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 4; k++) send_byte(payload[w][8*k +: 8], 1);
    send_byte(csum_of(3), 1);
    checks++; if (wr_count !== 3) begin errors++; $display("[TB] FAIL toggle_wr_count: got %0d want 3", wr_count); end
    checks++; if (log_addr[0] !== 8'd0 || log_addr[1] !== 8'd1 || log_addr[2] !== 8'd2) begin errors++; $display("[TB] FAIL toggle_addr_order: got %0d %0d %0d want 0 1 2", log_addr[0], log_addr[1], log_addr[2]); end
    checks++; if (log_data[0] !== 32'h11223344 || log_data[1] !== 32'hDEADBEEF || log_data[2] !== 32'h00000001) begin errors++; $display("[TB] FAIL toggle_data: got %h %h %h want 11223344 deadbeef 00000001", log_data[0], log_data[1], log_data[2]); end
    checks++; if (ready_viol !== 0) begin errors++; $display("[TB] FAIL toggle_ready_in_write: got %0d cycles with in_ready=1 want 0", ready_viol); end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("[TB] FAIL toggle_done: got done=%b error=%b want 1 0", done, error); end
  endtask

  task automatic test_zero_len();
    wr_count = 0;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (2) @(negedge clk);
    checks++; if ({error, done, cpu_rst, busy, in_ready} !== 5'b10100) begin errors++; $display("[TB] FAIL zero_len_status: got e/d/c/b/r=%b want 10100", {error, done, cpu_rst, busy, in_ready}); end
    checks++; if (wr_count !== 0) begin errors++; $display("[TB] FAIL zero_len_writes: got %0d want 0", wr_count); end
  endtask

  task automatic test_oversize();
    wr_count = 0;
    pulse_start();
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL start_clears_error: got %b want 0", error); end
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    repeat (2) @(negedge clk);
    checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL oversize_error: got error=%b done=%b want 1 0", error, done); end
    checks++; if (wr_count !== 0) begin errors++; $display("[TB] FAIL oversize_writes: got %0d want 0", wr_count); end
  endtask

  task automatic test_full_capacity();
    wr_count = 0;
    for (int i = 0; i < 256; i++)
      payload[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    pulse_start();
    send_frame(16'h0100, 256, 8'h00, 0);
    checks++; if (wr_count !== 256) begin errors++; $display("[TB] FAIL full_wr_count: got %0d want 256", wr_count); end
    checks++; if (log_data[0] !== 32'h03020100 || log_addr[255] !== 8'hFF || log_data[255] !== 32'hFFFEFDFC) begin errors++; $display("[TB] FAIL full_ends: got %h %h/%h want 03020100 ff/fffefdfc", log_data[0], log_addr[255], log_data[255]); end
    checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin errors++; $display("[TB] FAIL full_done: got done=%b cpu_rst=%b want 1 0", done, cpu_rst); end
  endtask

  task automatic test_bad_checksum();
    wr_count = 0;
    payload[0] = 32'h00A00513;
    pulse_start();
    send_frame(16'h0001, 1, 8'hB7, 0);
    checks++; if (wr_count !== 1 || log_data[0] !== 32'h00A00513) begin errors++; $display("[TB] FAIL badsum_write: got %0d writes data %h want 1 00a00513", wr_count, log_data[0]); end
    checks++; if ({error, done, cpu_rst} !== 3'b101) begin errors++; $display("[TB] FAIL badsum_status: got e/d/c=%b want 101", {error, done, cpu_rst}); end
  endtask

  task automatic test_reset_midframe();
    wr_count = 0;
    payload[0] = 32'h00A00513;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy, in_ready, error, done, cpu_rst} !== 5'b00001) begin errors++; $display("[TB] FAIL midreset_status: got b/r/e/d/c=%b want 00001", {busy, in_ready, error, done, cpu_rst}); end
    payload[0] = 32'hCAFEF00D;
    pulse_start();
    send_frame(16'h0001, 1, csum_of(1), 0);
    checks++; if (wr_count !== 1 || log_addr[0] !== 8'h00 || log_data[0] !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL midreset_write: got %0d writes %h/%h want 1 00/cafef00d", wr_count, log_addr[0], log_data[0]); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL midreset_done: got %b want 1", done); end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    test_reset();
    test_single_word();
    test_toggle_valid();
    test_zero_len();
    test_oversize();
    test_full_capacity();
    test_bad_checksum();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
